// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-2 packet stream demultiplexer.
package stream_demux_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W      = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;
endpackage

// File: rtl/stream_demux1to2_out_slot.sv
// One-entry output register: load takes priority over drain; latency 1.
// Data/last hold while valid is high and ready is low.
module out_slot
   import stream_demux_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              last_q, last_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = in_data;
         last_d  = in_last;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_last  = last_q;
endmodule

// File: rtl/stream_demux1to2.sv
// Packet-locked 1-to-2 stream demux with per-output completed-packet counters; latency 1.
// in_ready follows only the routed output's slot, so a stalled output never blocks the other.
module stream_demux1to2
   import stream_demux_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              sel,
   output logic              out0_valid,
   input  logic              out0_ready,
   output logic [DATA_W-1:0] out0_data,
   output logic              out0_last,
   output logic              out1_valid,
   input  logic              out1_ready,
   output logic [DATA_W-1:0] out1_data,
   output logic              out1_last,
   output logic [CNT_W-1:0]  pkt_cnt0,
   output logic [CNT_W-1:0]  pkt_cnt1
);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;
   logic             route;
   logic             accept;
   logic             load0, load1;

   // sel only matters at a packet boundary; mid-packet the lock decides.
   always_comb begin
      case (state_q)
         LOCK0:   route = 1'b0;
         LOCK1:   route = 1'b1;
         default: route = sel;
      endcase
   end

   assign in_ready = route ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
   assign accept   = in_valid && in_ready;
   assign load0    = accept && !route;
   assign load1    = accept && route;

   always_comb begin
      state_d = state_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      if (accept) begin
         if (in_last) begin
            state_d = IDLE;
            if (load0 && cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + 1'b1;
            if (load1 && cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + 1'b1;
         end else if (state_q == IDLE) begin
            state_d = route ? LOCK1 : LOCK0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   out_slot #(.DATA_W(DATA_W)) u_slot0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load0),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out0_valid),
      .out_ready (out0_ready),
      .out_data  (out0_data),
      .out_last  (out0_last)
   );

   out_slot #(.DATA_W(DATA_W)) u_slot1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load1),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out1_valid),
      .out_ready (out1_ready),
      .out_data  (out1_data),
      .out_last  (out1_last)
   );

   assign pkt_cnt0 = cnt0_q;
   assign pkt_cnt1 = cnt1_q;
endmodule

// File: tb/tb_stream_demux1to2.sv
// Random and directed stimulus for stream_demux1to2, checked each cycle against a queue-based model.
module tb_stream_demux1to2;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic       in_last = 1'b0;
   logic       sel = 1'b0;
   logic       out0_valid, out1_valid;
   logic       out0_ready = 1'b0, out1_ready = 1'b0;
   logic [7:0] out0_data, out1_data;
   logic       out0_last, out1_last;
   logic [7:0] pkt_cnt0, pkt_cnt1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   // Model: each output is a queue of at most one beat; lock is -1 between packets.
   beat_t q0[$];
   beat_t q1[$];
   int    lock = -1;
   int    cnt0 = 0;
   int    cnt1 = 0;

   stream_demux1to2 #(.DATA_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .sel        (sel),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out0_last  (out0_last),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .out1_last  (out1_last),
      .pkt_cnt0   (pkt_cnt0),
      .pkt_cnt1   (pkt_cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      lock = -1;
      cnt0 = 0;
      cnt1 = 0;
   endtask

   // Compare all outputs against the model, advance the model over the coming edge, wait for next negedge.
   task automatic step();
      int    route;
      bit    exp_rdy;
      bit    acc;
      beat_t b;
      #1;
      route   = (lock < 0) ? int'(sel) : lock;
      exp_rdy = (route == 1) ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
      chk("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
      if (q0.size() != 0) begin
         chk("out0_data", {24'd0, out0_data}, {24'd0, q0[0].d});
         chk("out0_last", {31'd0, out0_last}, {31'd0, q0[0].l});
      end
      if (q1.size() != 0) begin
         chk("out1_data", {24'd0, out1_data}, {24'd0, q1[0].d});
         chk("out1_last", {31'd0, out1_last}, {31'd0, q1[0].l});
      end
      chk("pkt_cnt0", {24'd0, pkt_cnt0}, cnt0);
      chk("pkt_cnt1", {24'd0, pkt_cnt1}, cnt1);

      acc = in_valid && exp_rdy;
      if (q0.size() != 0 && out0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
      if (acc) begin
         b.d = in_data;
         b.l = in_last;
         if (route == 1) q1.push_back(b);
         else            q0.push_back(b);
         if (in_last) begin
            if (route == 1) cnt1 = (cnt1 < 255) ? cnt1 + 1 : 255;
            else            cnt0 = (cnt0 < 255) ? cnt0 + 1 : 255;
            lock = -1;
         end else begin
            lock = route;
         end
      end
      @(negedge clk);
   endtask

   task automatic beat(input logic v, input logic [7:0] d, input logic l, input logic s);
      in_valid = v;
      in_data  = d;
      in_last  = l;
      sel      = s;
      step();
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("rst in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst out0_valid", {31'd0, out0_valid}, 32'd0);
      chk("rst out1_valid", {31'd0, out1_valid}, 32'd0);
      chk("rst out0_data", {24'd0, out0_data}, 32'd0);
      chk("rst out1_data", {24'd0, out1_data}, 32'd0);
      chk("rst pkt_cnt0", {24'd0, pkt_cnt0}, 32'd0);
      chk("rst pkt_cnt1", {24'd0, pkt_cnt1}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Three-beat packet to out0.
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      beat(1'b1, 8'h11, 1'b0, 1'b0);
      chk("p3 b0 data", {24'd0, out0_data}, 32'h11);
      beat(1'b1, 8'h22, 1'b0, 1'b0);
      chk("p3 b1 data", {24'd0, out0_data}, 32'h22);
      beat(1'b1, 8'h33, 1'b1, 1'b0);
      chk("p3 b2 data", {24'd0, out0_data}, 32'h33);
      chk("p3 b2 last", {31'd0, out0_last}, 32'd1);
      chk("p3 out1_valid", {31'd0, out1_valid}, 32'd0);
      chk("p3 pkt_cnt0", {24'd0, pkt_cnt0}, 32'd1);

      // sel toggles mid-packet; the lock keeps both beats on out1.
      beat(1'b1, 8'hA0, 1'b0, 1'b1);
      beat(1'b1, 8'hA1, 1'b1, 1'b0);
      chk("lock out1_data", {24'd0, out1_data}, 32'hA1);
      chk("lock out0_valid", {31'd0, out0_valid}, 32'd0);
      chk("lock pkt_cnt1", {24'd0, pkt_cnt1}, 32'd1);
      beat(1'b0, 8'h00, 1'b0, 1'b0);

      // Stall on out0, then release.
      out0_ready = 1'b0;
      beat(1'b1, 8'h55, 1'b1, 1'b0);
      in_valid = 1'b0;
      #1;
      chk("stall in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall out0_data", {24'd0, out0_data}, 32'h55);
      step();
      chk("stall hold data", {24'd0, out0_data}, 32'h55);
      out0_ready = 1'b1;
      #1;
      chk("release in_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("release out0_valid", {31'd0, out0_valid}, 32'd0);

      // out0 stalled does not block a packet to out1.
      out0_ready = 1'b0;
      beat(1'b1, 8'h55, 1'b1, 1'b0);
      beat(1'b1, 8'h66, 1'b1, 1'b1);
      chk("bypass out1_data", {24'd0, out1_data}, 32'h66);
      chk("bypass pkt_cnt1", {24'd0, pkt_cnt1}, 32'd2);
      chk("bypass out0_data", {24'd0, out0_data}, 32'h55);
      out0_ready = 1'b1;
      beat(1'b0, 8'h00, 1'b0, 1'b0);

      // 300 single-beat packets to out0: counter saturates.
      for (int i = 0; i < 300; i++) beat(1'b1, 8'(i), 1'b1, 1'b0);
      chk("sat pkt_cnt0", {24'd0, pkt_cnt0}, 32'd255);
      beat(1'b0, 8'h00, 1'b0, 1'b0);

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         out0_ready = ($urandom_range(3) != 0);
         out1_ready = ($urandom_range(3) != 0);
         beat(1'($urandom), 8'($urandom), ($urandom_range(2) == 0), 1'($urandom));
      end

      // Asynchronous reset while locked to out1.
      out1_ready = 1'b0;
      beat(1'b0, 8'h00, 1'b0, 1'b0);
      beat(1'b1, 8'h77, 1'b0, 1'b1);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst out0_valid", {31'd0, out0_valid}, 32'd0);
      chk("arst out1_valid", {31'd0, out1_valid}, 32'd0);
      chk("arst pkt_cnt0", {24'd0, pkt_cnt0}, 32'd0);
      chk("arst pkt_cnt1", {24'd0, pkt_cnt1}, 32'd0);
      chk("arst out1_data", {24'd0, out1_data}, 32'd0);
      chk("arst in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      out0_ready = 1'b0;
      beat(1'b1, 8'hAB, 1'b1, 1'b0);
      chk("post rst out0_valid", {31'd0, out0_valid}, 32'd1);
      chk("post rst out0_data", {24'd0, out0_data}, 32'hAB);
      chk("post rst out1_valid", {31'd0, out1_valid}, 32'd0);
      out0_ready = 1'b1;
      beat(1'b0, 8'h00, 1'b0, 1'b0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
